// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back slice.
package regfile_pkg;

    localparam int REG_COUNT  = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 32;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending scoreboard: one outstanding write per register,
// set on an accepted issue, cleared when the register file commits.
module regfile_scoreboard #(
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         issueValid_i,
    input  logic [ADDR_WIDTH-1:0]        issueReg_i,
    output logic                         issueReady_o,
    input  logic                         commitValid_i,
    input  logic [ADDR_WIDTH-1:0]        commitReg_i,
    input  logic [ADDR_WIDTH-1:0]        readReg1_i,
    input  logic [ADDR_WIDTH-1:0]        readReg2_i,
    output logic                         pending1_o,
    output logic                         pending2_o,
    output logic [(1<<ADDR_WIDTH)-1:0]   pendingVector_o
);

    localparam int NumRegs = 1 << ADDR_WIDTH;

    logic [NumRegs-1:0] pending_q, pending_d;
    logic               issueAccept;

    // Refusal looks only at the current bit, so a retry on the commit edge is still refused.
    assign issueReady_o = ~pending_q[issueReg_i];
    assign issueAccept  = issueValid_i & issueReady_o & (issueReg_i != '0);

    always_comb begin
        pending_d = pending_q;
        if (commitValid_i) begin
            pending_d[commitReg_i] = 1'b0;
        end
        if (issueAccept) begin
            pending_d[issueReg_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending1_o      = pending_q[readReg1_i];
    assign pending2_o      = pending_q[readReg2_i];
    assign pendingVector_o = pending_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter between ALU and memory unit, feeding the
// register file's single write port, plus the RAW hazard scoreboard.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         IssueValid,
    input  logic [ADDR_WIDTH-1:0]        IssueReg,
    output logic                         IssueReady,
    input  logic                         AluValid,
    input  logic [ADDR_WIDTH-1:0]        AluReg,
    input  logic [DATA_WIDTH-1:0]        AluData,
    output logic                         AluReady,
    input  logic                         MemValid,
    input  logic [ADDR_WIDTH-1:0]        MemReg,
    input  logic [DATA_WIDTH-1:0]        MemData,
    output logic                         MemReady,
    input  logic [ADDR_WIDTH-1:0]        ReadRegister1,
    input  logic [ADDR_WIDTH-1:0]        ReadRegister2,
    output logic                         Pending1,
    output logic                         Pending2,
    output logic [(1<<ADDR_WIDTH)-1:0]   PendingVector,
    output logic [DATA_WIDTH-1:0]        WriteData,
    output logic [ADDR_WIDTH-1:0]        WriteRegister,
    output logic                         RegWrite,
    output logic                         Orphan
);

    import regfile_pkg::*;

    localparam int NumRegs = 1 << ADDR_WIDTH;

    req_e                  rrPtr_q, rrPtr_d;
    logic                  aluGrant, memGrant, anyGrant;
    logic [ADDR_WIDTH-1:0] grantReg;
    logic [DATA_WIDTH-1:0] grantData;
    logic                  regWrite_q, regWrite_d;
    logic [ADDR_WIDTH-1:0] writeReg_q, writeReg_d;
    logic [DATA_WIDTH-1:0] writeData_q, writeData_d;
    logic                  orphan_q, orphan_d;
    logic [NumRegs-1:0]    pendingVec;

    // The pointer names who wins a tie; after any grant it favours the loser.
    always_comb begin
        aluGrant  = AluValid & (~MemValid | (rrPtr_q == REQ_ALU));
        memGrant  = MemValid & (~AluValid | (rrPtr_q == REQ_MEM));
        anyGrant  = aluGrant | memGrant;
        grantReg  = memGrant ? MemReg  : AluReg;
        grantData = memGrant ? MemData : AluData;
        rrPtr_d   = rrPtr_q;
        if (aluGrant) begin
            rrPtr_d = REQ_MEM;
        end else if (memGrant) begin
            rrPtr_d = REQ_ALU;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rrPtr_q <= REQ_ALU;
        end else begin
            rrPtr_q <= rrPtr_d;
        end
    end

    always_comb begin
        regWrite_d  = 1'b0;
        writeReg_d  = writeReg_q;
        writeData_d = writeData_q;
        orphan_d    = orphan_q;
        if (anyGrant) begin
            writeReg_d  = grantReg;
            writeData_d = grantData;
            regWrite_d  = (grantReg != '0);
            if ((grantReg != '0) && !pendingVec[grantReg]) begin
                orphan_d = 1'b1;
            end
        end
    end

    // Async reset also kills an in-flight write before the register file samples it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            regWrite_q  <= 1'b0;
            writeReg_q  <= '0;
            writeData_q <= '0;
            orphan_q    <= 1'b0;
        end else begin
            regWrite_q  <= regWrite_d;
            writeReg_q  <= writeReg_d;
            writeData_q <= writeData_d;
            orphan_q    <= orphan_d;
        end
    end

    regfile_scoreboard #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_scoreboard (
        .clk_i          (Clk),
        .rst_i          (Reset),
        .issueValid_i   (IssueValid),
        .issueReg_i     (IssueReg),
        .issueReady_o   (IssueReady),
        .commitValid_i  (regWrite_q),
        .commitReg_i    (writeReg_q),
        .readReg1_i     (ReadRegister1),
        .readReg2_i     (ReadRegister2),
        .pending1_o     (Pending1),
        .pending2_o     (Pending2),
        .pendingVector_o(pendingVec)
    );

    assign AluReady      = aluGrant;
    assign MemReady      = memGrant;
    assign PendingVector = pendingVec;
    assign WriteData     = writeData_q;
    assign WriteRegister = writeReg_q;
    assign RegWrite      = regWrite_q;
    assign Orphan        = orphan_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed bench for regfile_wb_arbiter with a behavioural
// register file, a reference model and a commit scoreboard.
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        IssueValid = 1'b0;
    logic [4:0]  IssueReg = '0;
    logic        IssueReady;
    logic        AluValid = 1'b0, MemValid = 1'b0;
    logic [4:0]  AluReg = '0, MemReg = '0;
    logic [31:0] AluData = '0, MemData = '0;
    logic        AluReady, MemReady;
    logic [4:0]  ReadRegister1 = '0, ReadRegister2 = '0;
    logic        Pending1, Pending2;
    logic [31:0] PendingVector, WriteData;
    logic [4:0]  WriteRegister;
    logic        RegWrite, Orphan;

    int vectors = 0;
    int miscompares = 0;

    bit          pendM [32];
    bit          claimed [32];
    logic [31:0] rfM [32] = '{default: 32'h0};
    logic [31:0] rfDut [32] = '{default: 32'h0};
    bit          memTurn, orphanM, commitM;
    logic [4:0]  outRegM;
    logic [31:0] outDataM;
    wr_t         expQ [$];
    logic [4:0]  seenRegs [$];

    always #5 Clk = ~Clk;

    regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .Clk(Clk), .Reset(Reset),
        .IssueValid(IssueValid), .IssueReg(IssueReg), .IssueReady(IssueReady),
        .AluValid(AluValid), .AluReg(AluReg), .AluData(AluData), .AluReady(AluReady),
        .MemValid(MemValid), .MemReg(MemReg), .MemData(MemData), .MemReady(MemReady),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .Pending1(Pending1), .Pending2(Pending2), .PendingVector(PendingVector),
        .WriteData(WriteData), .WriteRegister(WriteRegister), .RegWrite(RegWrite),
        .Orphan(Orphan)
    );

    // Stand-in for the real register file: writes on the edge RegWrite is sampled high.
    always @(posedge Clk) begin
        if (RegWrite === 1'b1 && WriteRegister != 5'd0) rfDut[WriteRegister] <= WriteData;
    end

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every registered write must match the oldest grant the model predicted.
    always @(negedge Clk) begin : monitor
        wr_t e;
        if (!Reset && RegWrite === 1'b1) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL commitUnexpected: got write to R%0d, expected no write", WriteRegister);
            end else begin
                e = expQ.pop_front();
                checkValue("commitReg", 32'(WriteRegister), 32'(e.r));
                checkValue("commitData", WriteData, e.d);
                seenRegs.push_back(WriteRegister);
            end
        end
    end

    task automatic resetModel();
        for (int i = 0; i < 32; i++) begin
            pendM[i]   = 1'b0;
            claimed[i] = 1'b0;
        end
        memTurn  = 1'b0;
        orphanM  = 1'b0;
        commitM  = 1'b0;
        outRegM  = '0;
        outDataM = '0;
        expQ.delete();
    endtask

    task automatic checkOutput(input bit gA, input bit gM, input bit issueOk);
        logic [31:0] pv;
        for (int i = 0; i < 32; i++) pv[i] = pendM[i];
        checkValue("IssueReady", 32'(IssueReady), 32'(issueOk));
        checkValue("AluReady", 32'(AluReady), 32'(gA));
        checkValue("MemReady", 32'(MemReady), 32'(gM));
        checkValue("Pending1", 32'(Pending1), 32'(pendM[ReadRegister1]));
        checkValue("Pending2", 32'(Pending2), 32'(pendM[ReadRegister2]));
        checkValue("PendingVector", PendingVector, pv);
        checkValue("RegWrite", 32'(RegWrite), 32'(commitM));
        checkValue("WriteRegister", 32'(WriteRegister), 32'(outRegM));
        checkValue("WriteData", WriteData, outDataM);
        checkValue("Orphan", 32'(Orphan), 32'(orphanM));
        checkValue("RfRead1", rfDut[ReadRegister1], rfM[ReadRegister1]);
    endtask

    // One clock cycle: drive, predict, check at negedge, advance the model at posedge.
    task automatic applyStimulus(input bit iv, input logic [4:0] ir,
                                 input bit av, input logic [4:0] ar, input logic [31:0] ad,
                                 input bit mv, input logic [4:0] mr, input logic [31:0] md,
                                 output bit aRdy, output bit mRdy);
        bit          gA, gM, issueOk, orph;
        logic [4:0]  gR;
        logic [31:0] gD;
        wr_t         w;
        IssueValid = iv; IssueReg = ir;
        AluValid = av; AluReg = ar; AluData = ad;
        MemValid = mv; MemReg = mr; MemData = md;
        ReadRegister1 = 5'($urandom_range(0, 31));
        ReadRegister2 = 5'($urandom_range(0, 31));
        gA      = av && (!mv || !memTurn);
        gM      = mv && (!av || memTurn);
        gR      = gM ? mr : ar;
        gD      = gM ? md : ad;
        issueOk = !pendM[ir];
        orph    = (gA || gM) && (gR != 5'd0) && !pendM[gR];
        @(negedge Clk);
        checkOutput(gA, gM, issueOk);
        aRdy = AluReady;
        mRdy = MemReady;
        @(posedge Clk);
        if (commitM) begin
            pendM[outRegM]   = 1'b0;
            rfM[outRegM]     = outDataM;
            claimed[outRegM] = 1'b0;
        end
        if (iv && issueOk && ir != 5'd0) pendM[ir] = 1'b1;
        if (orph) orphanM = 1'b1;
        commitM = 1'b0;
        if (gA || gM) begin
            outRegM  = gR;
            outDataM = gD;
            memTurn  = gA;
            if (gR != 5'd0) begin
                commitM = 1'b1;
                w.r = gR;
                w.d = gD;
                expQ.push_back(w);
            end
        end
        #1;
    endtask

    task automatic pickReg(output bit v, output logic [4:0] r);
        int cand [$];
        for (int i = 1; i < 32; i++) if (pendM[i] && !claimed[i]) cand.push_back(i);
        v = 1'b0;
        r = '0;
        if ($urandom_range(0, 7) == 0) begin
            v = 1'b1;
        end else if (cand.size() > 0) begin
            r = 5'(cand[$urandom_range(0, cand.size() - 1)]);
            v = 1'b1;
            claimed[r] = 1'b1;
        end
    endtask

    initial begin
        bit          aR, mR, aV, mV;
        logic [4:0]  aRg, mRg, ir;
        logic [31:0] aDt, mDt;
        int          ai, mi, guard;
        int          expOrder [4] = '{1, 3, 2, 4};

        resetModel();
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        checkValue("RstRegWrite", 32'(RegWrite), 32'd0);
        checkValue("RstWriteData", WriteData, 32'd0);
        checkValue("RstWriteRegister", 32'(WriteRegister), 32'd0);
        checkValue("RstPendingVector", PendingVector, 32'd0);
        checkValue("RstOrphan", 32'(Orphan), 32'd0);

        // Contention: grants alternate, commits arrive R1, R3, R2, R4.
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 5'(i), 1'b0, '0, '0, 1'b0, '0, '0, aR, mR);
        seenRegs.delete();
        ai = 0; mi = 0; guard = 0;
        while ((ai < 2 || mi < 2) && guard < 10) begin
            applyStimulus(1'b0, '0, ai < 2, 5'(1 + ai), 32'h1000 + 32'(ai),
                          mi < 2, 5'(3 + mi), 32'h2000 + 32'(mi), aR, mR);
            if (aR) ai++;
            if (mR) mi++;
            guard++;
        end
        repeat (2) applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0, aR, mR);
        checkValue("ContentionCount", 32'(seenRegs.size()), 32'd4);
        for (int k = 0; k < 4 && k < seenRegs.size(); k++)
            checkValue("ContentionOrder", 32'(seenRegs[k]), 32'(expOrder[k]));

        // Single ALU write to R5, visible two cycles after the grant.
        applyStimulus(1'b1, 5'd5, 1'b0, '0, '0, 1'b0, '0, '0, aR, mR);
        applyStimulus(1'b0, '0, 1'b1, 5'd5, 32'h1234_5678, 1'b0, '0, '0, aR, mR);
        checkValue("SingleAluReady", 32'(aR), 32'd1);
        checkValue("SingleRegWrite", 32'(RegWrite), 32'd1);
        checkValue("SingleWriteReg", 32'(WriteRegister), 32'd5);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0, aR, mR);
        ReadRegister1 = 5'd5;
        #1;
        checkValue("SinglePending1", 32'(Pending1), 32'd0);
        checkValue("SingleRf5", rfDut[5], 32'h1234_5678);

        // Register 0: issue sets nothing, write is granted but never committed.
        applyStimulus(1'b1, 5'd0, 1'b0, '0, '0, 1'b0, '0, '0, aR, mR);
        checkValue("R0Pending", PendingVector, 32'd0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF, aR, mR);
        checkValue("R0MemReady", 32'(mR), 32'd1);
        checkValue("R0RegWrite", 32'(RegWrite), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0, aR, mR);
        checkValue("R0Rf", rfDut[0], 32'd0);

        // Double issue and retry on the commit edge.
        applyStimulus(1'b1, 5'd7, 1'b0, '0, '0, 1'b0, '0, '0, aR, mR);
        applyStimulus(1'b1, 5'd7, 1'b0, '0, '0, 1'b0, '0, '0, aR, mR);
        checkValue("DblPending7", 32'(PendingVector[7]), 32'd1);
        applyStimulus(1'b1, 5'd7, 1'b1, 5'd7, 32'h0000_0777, 1'b0, '0, '0, aR, mR);
        applyStimulus(1'b1, 5'd7, 1'b0, '0, '0, 1'b0, '0, '0, aR, mR);
        checkValue("SameEdgeRefused", 32'(PendingVector[7]), 32'd0);
        applyStimulus(1'b1, 5'd7, 1'b0, '0, '0, 1'b0, '0, '0, aR, mR);
        checkValue("RetryAccepted", 32'(PendingVector[7]), 32'd1);
        applyStimulus(1'b0, '0, 1'b1, 5'd7, 32'h0000_0778, 1'b0, '0, '0, aR, mR);

        // Randomised traffic; R9 is never issued so it stays free for the orphan case.
        aV = 1'b0; mV = 1'b0; aRg = '0; mRg = '0; aDt = '0; mDt = '0;
        for (int c = 0; c < 300; c++) begin
            if (!aV && $urandom_range(0, 1) == 1) begin
                pickReg(aV, aRg);
                aDt = $urandom();
            end
            if (!mV && $urandom_range(0, 1) == 1) begin
                pickReg(mV, mRg);
                mDt = $urandom();
            end
            ir = 5'($urandom_range(0, 31));
            if (ir == 5'd9) ir = 5'd8;
            applyStimulus(1'($urandom_range(0, 1)), ir, aV, aRg, aDt, mV, mRg, mDt, aR, mR);
            if (aR) aV = 1'b0;
            if (mR) mV = 1'b0;
        end
        guard = 0;
        while ((aV || mV) && guard < 20) begin
            applyStimulus(1'b0, '0, aV, aRg, aDt, mV, mRg, mDt, aR, mR);
            if (aR) aV = 1'b0;
            if (mR) mV = 1'b0;
            guard++;
        end
        if (aV || mV) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drainTimeout: got requests still pending, expected all granted");
        end
        repeat (2) applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0, aR, mR);

        // Orphan: write to a register nobody issued.
        checkValue("OrphanClear", 32'(Orphan), 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 5'd9, 32'h0909_0909, 1'b0, '0, '0, aR, mR);
        checkValue("OrphanAluReady", 32'(aR), 32'd1);
        repeat (3) applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0, aR, mR);
        checkValue("OrphanSticky", 32'(Orphan), 32'd1);
        checkValue("OrphanRf9", rfDut[9], 32'h0909_0909);

        // Reset while the R12 write is in flight.
        applyStimulus(1'b1, 5'd12, 1'b0, '0, '0, 1'b0, '0, '0, aR, mR);
        applyStimulus(1'b0, '0, 1'b1, 5'd12, 32'hCAFE_F00D, 1'b0, '0, '0, aR, mR);
        IssueValid = 1'b0; AluValid = 1'b0; MemValid = 1'b0;
        checkValue("MidRegWriteBefore", 32'(RegWrite), 32'd1);
        Reset = 1'b1;
        #1;
        checkValue("MidRegWriteDrop", 32'(RegWrite), 32'd0);
        checkValue("MidPendingVector", PendingVector, 32'd0);
        checkValue("MidOrphan", 32'(Orphan), 32'd0);
        resetModel();
        @(posedge Clk);
        #1;
        checkValue("MidRf12", rfDut[12], rfM[12]);
        Reset = 1'b0;
        applyStimulus(1'b0, '0, 1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 32'h2, aR, mR);
        checkValue("PtrAfterReset", 32'(aR), 32'd1);
        repeat (2) applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0, aR, mR);

        checkValue("QueueEmpty", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
